mux_arb_reg: RTL and testbench

- Parametrised successor to the pipeline's 2:1 selector: an NCH-input, NBITS-wide registered multiplexer with valid/ready handshake on every input and on the output.
- Two runtime modes: external select, or round-robin arbitration among valid inputs.
- One output register stage; it sits between pipeline stages and replaces the combinational selectors wherever back-pressure is needed.

---
 rtl/mux_pkg.sv | 19 +
 rtl/mux_arb_reg_rr_arbiter.sv | 36 +++
 rtl/mux_arb_reg.sv | 147 ++++++++++++++
 tb/tb_mux_arb_reg.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the registered N:1 multiplexer/arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mux_pkg;

   localparam logic MODE_SEL = 1'b0;
   localparam logic MODE_RR  = 1'b1;

   localparam int NBITS_DEF = 7;

   // Smallest r with 2**r >= v; used to size and sanity-check index widths.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/mux_arb_reg_rr_arbiter.sv
// Round-robin arbiter: first valid channel at or above ptr, wrapping modulo NCH.
// Latency: combinational.
// Backpressure: none; the caller qualifies the grant with its own load condition.
import mux_pkg::*;

module rr_arbiter #(
   parameter int NCH = 4,
   parameter int IW  = (clog2(NCH) < 1) ? 1 : clog2(NCH)
) (
   input  logic [NCH-1:0] valid,
   input  logic [IW-1:0]  ptr,
   output logic [NCH-1:0] grant,
   output logic [IW-1:0]  idx
);

   logic found;

   // Scan NCH positions starting at ptr; the first valid one wins.
   always_comb begin
      int c;
      c     = 0;
      grant = '0;
      idx   = '0;
      found = 1'b0;
      for (int k = 0; k < NCH; k++) begin
         c = int'(ptr) + k;
         if (c >= NCH) c = c - NCH;
         if (!found && valid[c]) begin
            found    = 1'b1;
            grant[c] = 1'b1;
            idx      = IW'(c);
         end
      end
   end

endmodule

// File: rtl/mux_arb_reg.sv
// Registered NCH:1 mux with select or round-robin grant; MUX_ARB_LOCK_EN adds packet lock via in_last.
// Latency: 1 cycle from input transfer to out_valid.
// Backpressure: in_ready only when the output register can load (!out_valid || out_ready); full rate back-to-back.
import mux_pkg::*;

module mux_arb_reg #(
   parameter int NBITS = NBITS_DEF,
   parameter int NCH   = 4,
   parameter int SELW  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCH*NBITS-1:0] in_data,
   input  logic [NCH-1:0]       in_valid,
   output logic [NCH-1:0]       in_ready,
   input  logic [SELW-1:0]      sel,
   input  logic                 mode,
   output logic [NBITS-1:0]     out_data,
   output logic [SELW-1:0]      out_ch,
   output logic                 out_valid,
   input  logic                 out_ready
`ifdef MUX_ARB_LOCK_EN
   ,input logic [NCH-1:0]       in_last
`endif
);

   localparam int IW = (clog2(NCH) < 1) ? 1 : clog2(NCH);

   if (NCH < 2 || NCH > 16) begin : g_bad_nch
      $error("mux_arb_reg: NCH must be in 2..16");
   end
   if (SELW < IW) begin : g_bad_selw
      $error("mux_arb_reg: SELW too narrow for NCH");
   end

   logic [SELW-1:0]  rr_ptr;
   logic [NCH-1:0]   sel_grant;
   logic [NCH-1:0]   rr_grant;
   logic [IW-1:0]    rr_idx;
   logic [NCH-1:0]   grant;
   logic [SELW-1:0]  grant_idx;
   logic [NBITS-1:0] grant_data;
   logic             load;
   logic             xfer;
   logic             ptr_adv;

   assign load = !out_valid || out_ready;

   rr_arbiter #(.NCH(NCH), .IW(IW)) u_rr (
      .valid (in_valid),
      .ptr   (rr_ptr[IW-1:0]),
      .grant (rr_grant),
      .idx   (rr_idx)
   );

   // Select-mode grant; out-of-range sel simply matches nothing.
   always_comb begin
      sel_grant = '0;
      for (int i = 0; i < NCH; i++)
         sel_grant[i] = in_valid[i] && (sel == SELW'(i));
   end

`ifdef MUX_ARB_LOCK_EN
   logic            lock_vld;
   logic [SELW-1:0] lock_ch;

   // A locked channel keeps the grant regardless of mode, sel or rr_ptr.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      if (lock_vld) begin
         for (int i = 0; i < NCH; i++)
            grant[i] = in_valid[i] && (lock_ch == SELW'(i));
         grant_idx = lock_ch;
      end else if (mode == MODE_RR) begin
         grant     = rr_grant;
         grant_idx = SELW'(rr_idx);
      end else begin
         grant     = sel_grant;
         grant_idx = sel;
      end
   end

   assign ptr_adv = xfer && in_last[grant_idx];

   // Lock opens on a non-last beat and releases when the last beat is taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         lock_vld <= 1'b0;
         lock_ch  <= '0;
      end else if (xfer) begin
         lock_vld <= !in_last[grant_idx];
         lock_ch  <= grant_idx;
      end
   end
`else
   // Per-beat grant chosen by the runtime mode.
   always_comb begin
      grant     = sel_grant;
      grant_idx = sel;
      if (mode == MODE_RR) begin
         grant     = rr_grant;
         grant_idx = SELW'(rr_idx);
      end
   end

   assign ptr_adv = xfer;
`endif

   assign in_ready = rst ? '0 : (grant & {NCH{load}});
   assign xfer     = |in_ready;

   // Pick the granted channel's data for the output register.
   always_comb begin
      grant_data = '0;
      for (int i = 0; i < NCH; i++)
         if (grant[i]) grant_data = in_data[i*NBITS +: NBITS];
   end

   // Output register: load on transfer, drain when consumed with nothing new.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
      end else if (load) begin
         if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_ch    <= grant_idx;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   // Round-robin pointer moves past the winner; frozen in select mode.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (ptr_adv && mode == MODE_RR) begin
         if (int'(grant_idx) == NCH - 1) rr_ptr <= '0;
         else                            rr_ptr <= grant_idx + SELW'(1);
      end
   end

endmodule

// File: tb/tb_mux_arb_reg.sv
// Directed bench for mux_arb_reg: select, round-robin, back-pressure, reset, out-of-range select.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_mux_arb_reg;

   logic        clk = 1'b0;
   logic        rst;
   logic [27:0] in_data;
   logic [3:0]  in_valid;
   logic [3:0]  in_ready;
   logic [1:0]  sel;
   logic        mode;
   logic [6:0]  out_data;
   logic [1:0]  out_ch;
   logic        out_valid;
   logic        out_ready;
`ifdef MUX_ARB_LOCK_EN
   logic [3:0]  in_last;
`endif

   logic [20:0] b_in_data;
   logic [2:0]  b_in_valid;
   logic [2:0]  b_in_ready;
   logic [1:0]  b_sel;
   logic        b_mode;
   logic [6:0]  b_out_data;
   logic [1:0]  b_out_ch;
   logic        b_out_valid;
   logic        b_out_ready;
`ifdef MUX_ARB_LOCK_EN
   logic [2:0]  b_in_last;
`endif

   int checks = 0;
   int errors = 0;

   logic [6:0] ch_dat [4] = '{7'h11, 7'h22, 7'h55, 7'h33};

   always #5 clk = ~clk;

   mux_arb_reg #(.NBITS(7), .NCH(4), .SELW(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sel       (sel),
      .mode      (mode),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef MUX_ARB_LOCK_EN
      ,.in_last  (in_last)
`endif
   );

   mux_arb_reg #(.NBITS(7), .NCH(3), .SELW(2)) dut3 (
      .clk       (clk),
      .rst       (rst),
      .in_data   (b_in_data),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .sel       (b_sel),
      .mode      (b_mode),
      .out_data  (b_out_data),
      .out_ch    (b_out_ch),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready)
`ifdef MUX_ARB_LOCK_EN
      ,.in_last  (b_in_last)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst         = 1'b1;
      in_data     = {ch_dat[3], ch_dat[2], ch_dat[1], ch_dat[0]};
      in_valid    = 4'b0000;
      sel         = 2'd0;
      mode        = 1'b0;
      out_ready   = 1'b1;
      b_in_data   = {7'h03, 7'h02, 7'h01};
      b_in_valid  = 3'b000;
      b_sel       = 2'd0;
      b_mode      = 1'b0;
      b_out_ready = 1'b1;
`ifdef MUX_ARB_LOCK_EN
      in_last     = 4'b1111;
      b_in_last   = 3'b111;
`endif

      // Reset state
      in_valid = 4'b1111;
      #1;
      chk("rst_in_ready", in_ready, 4'b0000);
      step();
      step();
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, 7'h00);
      chk("rst_out_ch", out_ch, 2'd0);

      // Select mode, sel=2, only ch2 valid
      rst      = 1'b0;
      in_valid = 4'b0100;
      sel      = 2'd2;
      mode     = 1'b0;
      #1;
      chk("sel_in_ready", in_ready, 4'b0100);
      step();
      chk("sel_out_valid", out_valid, 1'b1);
      chk("sel_out_data", out_data, 7'h55);
      chk("sel_out_ch", out_ch, 2'd2);

      // Round-robin, all valid, 8 back-to-back beats
      mode     = 1'b1;
      in_valid = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         #1;
         chk("rr_in_ready", in_ready, 4'b0001 << (k % 4));
         step();
         chk("rr_out_valid", out_valid, 1'b1);
         chk("rr_out_ch", out_ch, k % 4);
         chk("rr_out_data", out_data, ch_dat[k % 4]);
      end

      // Back-pressure: hold ch3 beat for 3 cycles
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp_in_ready", in_ready, 4'b0000);
         step();
         chk("bp_out_valid", out_valid, 1'b1);
         chk("bp_out_ch", out_ch, 2'd3);
         chk("bp_out_data", out_data, 7'h33);
      end
      out_ready = 1'b1;
      #1;
      chk("rel_in_ready", in_ready, 4'b0001);
      step();
      chk("rel_out_ch0", out_ch, 2'd0);
      chk("rel_out_data0", out_data, 7'h11);
      step();
      chk("rel_out_ch1", out_ch, 2'd1);
      chk("rel_out_valid", out_valid, 1'b1);

      // Reset pulse with rr_ptr=2 and a held beat
      rst = 1'b1;
      #1;
      chk("rst2_in_ready", in_ready, 4'b0000);
      step();
      chk("rst2_out_valid", out_valid, 1'b0);
      chk("rst2_out_data", out_data, 7'h00);
      chk("rst2_out_ch", out_ch, 2'd0);
      rst = 1'b0;
      #1;
      chk("rst2_rr_start", in_ready, 4'b0001);
      step();
      chk("rst2_rr_ch", out_ch, 2'd0);

      // Drain: nothing valid, consumer ready
      in_valid = 4'b0000;
      step();
      chk("drain_out_valid", out_valid, 1'b0);

      // Select mode on invalid channel gives no grant
      mode     = 1'b0;
      sel      = 2'd1;
      in_valid = 4'b1101;
      #1;
      chk("sel_invalid_rdy", in_ready, 4'b0000);
      step();
      chk("sel_invalid_vld", out_valid, 1'b0);

      // NCH=3 instance: sel=0 valid, then sel=3 out of range drains
      b_in_valid = 3'b001;
      b_sel      = 2'd0;
      step();
      chk("n3_out_valid", b_out_valid, 1'b1);
      chk("n3_out_data", b_out_data, 7'h01);
      b_sel      = 2'd3;
      b_in_valid = 3'b111;
      #1;
      chk("n3_sel3_rdy", b_in_ready, 3'b000);
      step();
      chk("n3_sel3_vld", b_out_valid, 1'b0);

`ifdef MUX_ARB_LOCK_EN
      // Packet lock: rr_ptr=1, ch1 sends 3 beats while ch0/ch2 valid
      mode     = 1'b1;
      in_valid = 4'b0111;
      for (int b = 0; b < 3; b++) begin
         in_last = (b == 2) ? 4'b1111 : 4'b1101;
         #1;
         chk("lock_in_ready", in_ready, 4'b0010);
         step();
         chk("lock_out_ch", out_ch, 2'd1);
      end
      in_last = 4'b1111;
      step();
      chk("lock_after_ch", out_ch, 2'd2);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
